// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over the imem req/ack bus and loads IF/ID.
// Redirects never squash: the word fetched while the branch sits in ID is
// the delay slot and is always delivered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request outstanding at pc; waiting for imem_ack
// S_HOLD  | word acked during a stall, parked in the hold buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fw_if_id_stall,
  input  logic                id_if_selfontepc,
  input  logic [1:0]          id_if_seltipopc,
  input  logic [31:0]         id_if_pcimd2ext,
  input  logic [31:0]         id_if_pcindex,
  input  logic [31:0]         id_if_rega,
  fetch_stage_if.master       imem,
  output logic [31:0]         if_id_instrucao,
  output logic [31:0]         if_id_proximopc,
  output logic                if_id_valid
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_plus4, tgt, next_pc;
  logic [31:0] hold_instr, hold_pc4, redir_tgt;
  logic        redir_pending, redirect_now;
  logic        load_fetch, load_hold, bubble, capture_hold, pc_update;

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = pc;
  assign redirect_now   = id_if_selfontepc && !fw_if_id_stall && (id_if_seltipopc != 2'b11);
  assign pc_update      = load_fetch || load_hold;

  // Redirect target select; JR/JALR targets are forced word-aligned.
  always_comb begin
    tgt = id_if_pcimd2ext;
    case (id_if_seltipopc)
      2'b00:   tgt = id_if_pcimd2ext;
      2'b01:   tgt = id_if_pcindex;
      2'b10:   tgt = {id_if_rega[31:2], 2'b00};
      default: tgt = id_if_pcimd2ext;
    endcase
  end

  // Next PC: a live redirect wins over a parked one, otherwise sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (redirect_now)       next_pc = tgt;
    else if (redir_pending) next_pc = redir_tgt;
  end

  // FSM next-state and IF/ID load decisions.
  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    load_fetch    = 1'b0;
    load_hold     = 1'b0;
    bubble        = 1'b0;
    capture_hold  = 1'b0;
    case (state)
      S_FETCH: begin
        imem.imem_req = !reset;
        if (imem.imem_ack) begin
          if (fw_if_id_stall) begin
            capture_hold = 1'b1;
            state_nxt    = S_HOLD;
          end else begin
            load_fetch = 1'b1;
          end
        end else if (!fw_if_id_stall) begin
          bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (!fw_if_id_stall) begin
          load_hold = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // PC, IF/ID, hold buffer and parked-redirect registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc              <= RESET_PC;
      if_id_instrucao <= 32'd0;
      if_id_proximopc <= 32'd0;
      if_id_valid     <= 1'b0;
      hold_instr      <= 32'd0;
      hold_pc4        <= 32'd0;
      redir_pending   <= 1'b0;
      redir_tgt       <= 32'd0;
    end else begin
      if (pc_update) pc <= next_pc;

      if (load_fetch) begin
        if_id_instrucao <= imem.imem_rdata;
        if_id_proximopc <= pc_plus4;
        if_id_valid     <= 1'b1;
      end else if (load_hold) begin
        if_id_instrucao <= hold_instr;
        if_id_proximopc <= hold_pc4;
        if_id_valid     <= 1'b1;
      end else if (bubble) begin
        if_id_instrucao <= 32'd0;
        if_id_proximopc <= 32'd0;
        if_id_valid     <= 1'b0;
      end

      if (capture_hold) begin
        hold_instr <= imem.imem_rdata;
        hold_pc4   <= pc_plus4;
      end

      // A redirect seen while no PC update happens is parked until the next one.
      if (pc_update) begin
        redir_pending <= 1'b0;
      end else if (redirect_now) begin
        redir_pending <= 1'b1;
        redir_tgt     <= tgt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency imem stub plus a transaction-level
// model of the fetch address stream and IF/ID deliveries.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        selfonte = 1'b0;
  logic [1:0]  sel = 2'b11;
  logic [31:0] imd = 32'd0, idx = 32'd0, rega = 32'd0;
  logic [31:0] instr, ppc;
  logic        valid;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clock            (clock),
    .reset            (reset),
    .fw_if_id_stall   (stall),
    .id_if_selfontepc (selfonte),
    .id_if_seltipopc  (sel),
    .id_if_pcimd2ext  (imd),
    .id_if_pcindex    (idx),
    .id_if_rega       (rega),
    .imem             (bus),
    .if_id_instrucao  (instr),
    .if_id_proximopc  (ppc),
    .if_id_valid      (valid)
  );

  always #5 clock = ~clock;

  // imem stub state
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [7:0]  mem_seq = 8'd0;
  int          max_lat = 1;
  int          lat;

  assign bus.imem_ack   = mem_ack;
  assign bus.imem_rdata = mem_rdata;

  // Memory stub: accepts a request, acks after 1..max_lat cycles with a one-cycle pulse.
  always @(posedge clock) begin
    if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt <= 1) begin
        mem_ack  <= 1'b1;
        mem_busy <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (bus.imem_req) begin
      lat = $urandom_range(max_lat, 1);
      mem_addr  <= bus.imem_addr;
      mem_rdata <= {mem_seq, bus.imem_addr[23:0]};
      mem_seq   <= mem_seq + 8'd1;
      if (lat == 1) mem_ack <= 1'b1;
      else begin
        mem_busy <= 1'b1;
        mem_cnt  <= lat - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int ndeliv = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] got_word[$];
  logic [31:0] got_addr[$];
  logic [31:0] latest;
  logic        have_latest = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, note pre-edge bus events, then check the model after the edge.
  task automatic step(input logic r, input logic st, input logic sf, input logic [1:0] sl,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic        ack_pre, acc, redir, pv, expect_v;
    logic [31:0] word_pre, addr_pre, acc_addr, t, pi, pp, w, ad, e;
    reset = r; stall = st; selfonte = sf; sel = sl; imd = a; idx = b; rega = c;
    #1;
    ack_pre  = mem_ack;
    word_pre = mem_rdata;
    addr_pre = mem_addr;
    acc      = bus.imem_req && !mem_ack && !mem_busy;
    acc_addr = bus.imem_addr;
    redir    = sf && !st && (sl != 2'b11) && !r;
    t = (sl == 2'b00) ? a : (sl == 2'b01) ? b : (c & 32'hFFFF_FFFC);
    pi = instr; pp = ppc; pv = valid;
    @(posedge clock);
    #1;
    if (r) begin
      exp_fetch.delete();
      got_word.delete();
      got_addr.delete();
      exp_fetch.push_back(RESET_PC);
      have_latest = 1'b0;
      chk("rst_instr", instr, 32'd0);
      chk("rst_proximopc", ppc, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_addr", bus.imem_addr, RESET_PC);
    end else begin
      if (acc) begin
        if (exp_fetch.size() == 0) begin
          chk("fetch_unexpected", acc_addr, 32'hDEAD_BEEF);
        end else begin
          e = exp_fetch.pop_front();
          chk("fetch_addr", acc_addr, e);
        end
      end
      if (ack_pre) begin
        got_word.push_back(word_pre);
        got_addr.push_back(addr_pre);
      end
      if (redir) begin
        latest = t;
        have_latest = 1'b1;
      end
      if (st) begin
        chk("stall_instr", instr, pi);
        chk("stall_proximopc", ppc, pp);
        chk("stall_valid", {31'd0, valid}, {31'd0, pv});
      end else begin
        expect_v = (got_word.size() != 0);
        chk("valid", {31'd0, valid}, {31'd0, expect_v});
        if (expect_v) begin
          w  = got_word.pop_front();
          ad = got_addr.pop_front();
          chk("instr", instr, w);
          chk("proximopc", ppc, ad + 32'd4);
          exp_fetch.push_back(have_latest ? latest : ad + 32'd4);
          have_latest = 1'b0;
          ndeliv++;
        end else begin
          chk("bubble_instr", instr, 32'd0);
          chk("bubble_proximopc", ppc, 32'd0);
        end
      end
      chk("req", {31'd0, bus.imem_req}, {31'd0, (got_word.size() == 0)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    // reset and sequential fetch, 1-cycle memory
    max_lat = 1;
    do_reset(2);
    idle(8);
    // stall across an ack
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0);
    idle(4);
    // branch via pcimd2ext
    step(1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0040, 32'd0, 32'd0);
    idle(6);
    // JR with unaligned rega while an ack is pending
    max_lat = 3;
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'd0, 32'd0, 32'h0000_1003);
    idle(10);
    // redirect during stall is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'b01, 32'd0, 32'h0000_2000, 32'd0);
    idle(8);
    // jump to last word, PC wraps to 0
    step(1'b0, 1'b0, 1'b1, 2'b01, 32'd0, 32'hFFFF_FFFC, 32'd0);
    idle(14);
    // reset mid-request; stale ack lands inside reset
    step(1'b0, 1'b0, 1'b0, 2'b11, 32'd0, 32'd0, 32'd0);
    do_reset(5);
    idle(6);
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(199, 0) == 0) begin
        do_reset(5);
        max_lat = $urandom_range(3, 1);
      end else begin
        step(1'b0, ($urandom_range(9, 0) < 3), ($urandom_range(4, 0) == 0),
             2'($urandom_range(3, 0)), $urandom, $urandom, $urandom);
      end
    end
    chk("deliveries_seen", {31'd0, (ndeliv >= 100)}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
